// File: rtl/magnetron_ctrl_pkg.sv
// rtl/magnetron_ctrl_pkg.sv - shared types for the magnetron cook controller
// Purpose: state encodings, button bit positions and the per-cycle event
//          priority encoder used by the controller FSM.
// Ports:   none (package).
package magnetron_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COOK  = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Bit positions inside the registered button vectors.
    localparam int BTN_START = 0;
    localparam int BTN_STOP  = 1;
    localparam int BTN_CLEAR = 2;

    // Encoding order mirrors priority: clear > door open > stop > start > tick.
    typedef enum logic [2:0] {
        EV_NONE      = 3'd0,
        EV_CLEAR     = 3'd1,
        EV_DOOR_OPEN = 3'd2,
        EV_STOP      = 3'd3,
        EV_START     = 3'd4,
        EV_TICK      = 3'd5
    } event_t;

    // Reduce all simultaneous causes in one cycle to the single winning event.
    function automatic event_t top_event(input logic clear, input logic door_open,
                                         input logic stop, input logic start,
                                         input logic tick);
        if (clear)          return EV_CLEAR;
        else if (door_open) return EV_DOOR_OPEN;
        else if (stop)      return EV_STOP;
        else if (start)     return EV_START;
        else if (tick)      return EV_TICK;
        return EV_NONE;
    endfunction

endpackage

// File: rtl/magnetron_ctrl_if.sv
// rtl/magnetron_ctrl_if.sv - front-panel / relay-side bundle of the cook controller
// Purpose: groups panel buttons, door switch, cook settings and the driver outputs.
// Ports (signals):
//   startn/stopn/clearn  active-low button levels
//   door_closed          1 = door closed
//   time_load            cook time in ticks (TIME_W)
//   power_level          duty level (PW)
//   magnetron_on/lamp_on/beep/done_pulse  drivers and completion pulse
//   time_left            remaining ticks
//   state                IDLE=0 COOK=1 PAUSE=2 DONE=3
interface magnetron_ctrl_if #(
    parameter int TIME_W = 12,
    parameter int PW     = 4
);
    logic              startn;
    logic              stopn;
    logic              clearn;
    logic              door_closed;
    logic [TIME_W-1:0] time_load;
    logic [PW-1:0]     power_level;
    logic              magnetron_on;
    logic              lamp_on;
    logic              beep;
    logic              done_pulse;
    logic [TIME_W-1:0] time_left;
    logic [1:0]        state;

    modport master (
        output startn, stopn, clearn, door_closed, time_load, power_level,
        input  magnetron_on, lamp_on, beep, done_pulse, time_left, state
    );

    modport slave (
        input  startn, stopn, clearn, door_closed, time_load, power_level,
        output magnetron_on, lamp_on, beep, done_pulse, time_left, state
    );
endinterface

// File: rtl/magnetron_ctrl_tick_prescaler.sv
// rtl/magnetron_ctrl_tick_prescaler.sv - clock divider producing one-cycle timer ticks
// Purpose: counts enabled clocks 0..DIV-1 and pulses tick on the last count.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   enable    advance the count this cycle (count is held otherwise)
//   clear     force the count back to 0 (wins over enable)
//   tick      high in the enabled cycle where the count is DIV-1
module tick_prescaler #(
    parameter int DIV = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = enable && (cnt == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/magnetron_ctrl.sv
// rtl/magnetron_ctrl.sv - oven cook controller: timer, pause/resume, duty cycling, beep
// Purpose: turns front-panel presses and the door switch into magnetron relay, lamp and
//          buzzer drive. An open door removes relay drive combinationally.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   io        magnetron_ctrl_if.slave: buttons, door, time/power settings in;
//             magnetron_on, lamp_on, beep, done_pulse, time_left, state out
module magnetron_ctrl
    import magnetron_pkg::*;
#(
    parameter  int CLK_DIV      = 100,
    parameter  int TIME_W       = 12,
    parameter  int POWER_LEVELS = 10,
    parameter  int BEEP_TICKS   = 3,
    localparam int PW           = $clog2(POWER_LEVELS + 1),
    localparam int BW           = (BEEP_TICKS > 1) ? $clog2(BEEP_TICKS + 1) : 1
) (
    input  logic              clk,
    input  logic              rst,
    magnetron_ctrl_if.slave   io
);

    state_t            state_q, state_d;
    logic [TIME_W-1:0] time_left_q, time_d;
    logic [PW-1:0]     phase_q, phase_d;
    logic [PW-1:0]     power_q, power_d;
    logic [BW-1:0]     beep_cnt_q, beep_d;
    logic              done_q, done_d;
    logic              mag_q;
    logic              load;

    logic [2:0]        btn_q, btn_prev;
    logic [2:0]        press;
    logic              presc_en;
    logic              tick;
    event_t            ev;

    // Out-of-range or zero power means full power.
    function automatic logic [PW-1:0] clamp_power(input logic [PW-1:0] p);
        if (p == '0 || int'(p) > POWER_LEVELS) return PW'(POWER_LEVELS);
        return p;
    endfunction

    // One register stage per button, then a falling-edge compare against the
    // previous registered value so a held button acts exactly once.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q    <= 3'b111;
            btn_prev <= 3'b111;
        end else begin
            btn_q    <= {io.clearn, io.stopn, io.startn};
            btn_prev <= btn_q;
        end
    end

    assign press = btn_prev & ~btn_q;

    // The prescaler only runs while cooking or beeping, and not in a cycle where
    // a higher-priority event is about to leave that state; this is what keeps
    // the count frozen across a pause.
    always_comb begin
        presc_en = 1'b0;
        if (state_q == S_COOK)
            presc_en = io.door_closed & ~press[BTN_CLEAR] & ~press[BTN_STOP];
        else if (state_q == S_DONE)
            presc_en = io.door_closed & ~(|press);
    end

    tick_prescaler #(.DIV(CLK_DIV)) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .enable (presc_en),
        .clear  (load),
        .tick   (tick)
    );

    assign ev = top_event(press[BTN_CLEAR], ~io.door_closed, press[BTN_STOP],
                          press[BTN_START], tick);

    always_comb begin
        state_d = state_q;
        time_d  = time_left_q;
        phase_d = phase_q;
        power_d = power_q;
        beep_d  = beep_cnt_q;
        done_d  = 1'b0;
        load    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ev == EV_START && io.time_load != '0) begin
                    state_d = S_COOK;
                    time_d  = io.time_load;
                    power_d = clamp_power(io.power_level);
                    phase_d = '0;
                    load    = 1'b1;
                end
            end
            S_COOK: begin
                case (ev)
                    EV_CLEAR: begin
                        state_d = S_IDLE;
                        time_d  = '0;
                    end
                    EV_DOOR_OPEN, EV_STOP: state_d = S_PAUSE;
                    default: begin
                        // A start press while cooking has no meaning; the tick still applies.
                        if (tick) begin
                            phase_d = (phase_q == PW'(POWER_LEVELS - 1)) ? '0 : phase_q + 1'b1;
                            if (time_left_q != '0)
                                time_d = time_left_q - 1'b1;
                            if (time_left_q == TIME_W'(1)) begin
                                state_d = S_DONE;
                                done_d  = 1'b1;
                                beep_d  = '0;
                            end
                        end
                    end
                endcase
            end
            S_PAUSE: begin
                case (ev)
                    EV_CLEAR, EV_STOP: begin
                        state_d = S_IDLE;
                        time_d  = '0;
                    end
                    EV_START: state_d = S_COOK;
                    default:  ;
                endcase
            end
            S_DONE: begin
                if (ev inside {EV_CLEAR, EV_DOOR_OPEN, EV_STOP, EV_START}) begin
                    state_d = S_IDLE;
                end else if (tick) begin
                    if (beep_cnt_q == BW'(BEEP_TICKS - 1))
                        state_d = S_IDLE;
                    else
                        beep_d = beep_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            time_left_q <= '0;
            phase_q     <= '0;
            power_q     <= PW'(POWER_LEVELS);
            beep_cnt_q  <= '0;
            done_q      <= 1'b0;
            mag_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            time_left_q <= time_d;
            phase_q     <= phase_d;
            power_q     <= power_d;
            beep_cnt_q  <= beep_d;
            done_q      <= done_d;
            mag_q       <= (state_q == S_COOK) && (phase_q < power_q);
        end
    end

    // Door gating is outside the register so an opening door cuts the relay
    // in the same cycle.
    assign io.magnetron_on = mag_q & io.door_closed;
    assign io.lamp_on      = (state_q == S_COOK) | ~io.door_closed;
    assign io.beep         = (state_q == S_DONE);
    assign io.done_pulse   = done_q;
    assign io.time_left    = time_left_q;
    assign io.state        = state_q;

endmodule

// File: tb/tb_magnetron_ctrl.sv
// tb/tb_magnetron_ctrl.sv - self-checking bench for magnetron_ctrl
module tb_magnetron_ctrl;
    import magnetron_pkg::*;

    localparam int CLK_DIV      = 4;
    localparam int TIME_W       = 8;
    localparam int POWER_LEVELS = 4;
    localparam int BEEP_TICKS   = 2;
    localparam int PW           = $clog2(POWER_LEVELS + 1);

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    magnetron_ctrl_if #(.TIME_W(TIME_W), .PW(PW)) bus ();

    magnetron_ctrl #(
        .CLK_DIV      (CLK_DIV),
        .TIME_W       (TIME_W),
        .POWER_LEVELS (POWER_LEVELS),
        .BEEP_TICKS   (BEEP_TICKS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One entry per cook run expected to complete.
    typedef struct {
        bit chk_mag;
        int mag;
        int cook;
        int beep;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   pushed    = 0;
    int   done_seen = 0;
    int   mag_cnt   = 0;
    int   cook_cnt  = 0;
    int   beep_cnt  = 0;
    int   exp_beep  = 0;
    bit   beep_pend = 1'b0;

    task automatic push_exp(input bit chk_mag, input int mag, input int cook, input int beep);
        exp_t x;
        x.chk_mag = chk_mag;
        x.mag     = mag;
        x.cook    = cook;
        x.beep    = beep;
        sb.push_back(x);
        pushed++;
    endtask

    // Per-episode counters, cleared whenever the controller is idle.
    always @(negedge clk) begin
        if (rst) begin
            mag_cnt   = 0;
            cook_cnt  = 0;
            beep_cnt  = 0;
            beep_pend = 1'b0;
        end else if (bus.state == S_IDLE) begin
            if (beep_pend) chk("beep_cycles", beep_cnt, exp_beep);
            beep_pend = 1'b0;
            mag_cnt   = 0;
            cook_cnt  = 0;
            beep_cnt  = 0;
        end else begin
            if (bus.magnetron_on) mag_cnt++;
            if (bus.state == S_COOK && bus.door_closed) cook_cnt++;
            if (bus.beep) beep_cnt++;
            if (bus.done_pulse) begin
                done_seen++;
                if (sb.size() == 0) begin
                    chk("sb_unexpected_done", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    if (e.chk_mag) chk("mag_cycles", mag_cnt, e.mag);
                    chk("cook_cycles", cook_cnt, e.cook);
                    exp_beep  = e.beep;
                    beep_pend = 1'b1;
                end
            end
        end
    end

    // Press lasts one cycle; returns one delta after the edge where it takes effect.
    task automatic press(input logic do_start, input logic do_stop, input logic do_clear);
        @(posedge clk); #1;
        bus.startn = ~do_start;
        bus.stopn  = ~do_stop;
        bus.clearn = ~do_clear;
        @(posedge clk); #1;
        bus.startn = 1'b1;
        bus.stopn  = 1'b1;
        bus.clearn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic wait_state(input logic [1:0] s, input int lim, input string tag);
        int n = 0;
        while (bus.state !== s && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk(tag, bus.state, s);
    endtask

    task automatic start_run(input int t, input int p);
        bus.time_load   = TIME_W'(t);
        bus.power_level = PW'(p);
        press(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        rst             = 1'b1;
        bus.startn      = 1'b1;
        bus.stopn       = 1'b1;
        bus.clearn      = 1'b1;
        bus.door_closed = 1'b1;
        bus.time_load   = '0;
        bus.power_level = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_state", bus.state, S_IDLE);
        chk("rst_time", bus.time_left, 0);
        chk("rst_mag", bus.magnetron_on, 0);
        chk("rst_beep", bus.beep, 0);
        chk("rst_done", bus.done_pulse, 0);
        chk("rst_lamp", bus.lamp_on, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Full power, 3 ticks.
        push_exp(1'b1, 12, 12, 8);
        start_run(3, 4);
        chk("t1_cook", bus.state, S_COOK);
        chk("t1_time", bus.time_left, 3);
        chk("t1_lamp", bus.lamp_on, 1);
        wait_state(S_IDLE, 300, "t1_idle");
        chk("t1_time_end", bus.time_left, 0);

        // Power 1 of 4: 4 clocks on, 12 off, twice.
        push_exp(1'b1, 8, 32, 8);
        start_run(8, 1);
        wait_state(S_IDLE, 300, "t2_idle");

        // Door opened mid-cook, then resumed.
        push_exp(1'b0, 0, 32, 8);
        start_run(8, 4);
        begin
            int n = 0;
            while (bus.time_left !== 5 && n < 300) begin
                @(negedge clk);
                n++;
            end
        end
        chk("t3_reach5", bus.time_left, 5);
        @(posedge clk); #1;
        chk("t3_mag_before", bus.magnetron_on, 1);
        bus.door_closed = 1'b0;
        #1;
        chk("t3_mag_drop", bus.magnetron_on, 0);
        chk("t3_lamp_open", bus.lamp_on, 1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("t3_pause", bus.state, S_PAUSE);
        chk("t3_held", bus.time_left, 5);
        press(1'b1, 1'b0, 1'b0);
        chk("t3_start_door_open", bus.state, S_PAUSE);
        bus.door_closed = 1'b1;
        press(1'b1, 1'b0, 1'b0);
        chk("t3_resume", bus.state, S_COOK);
        chk("t3_resume_time", bus.time_left, 5);
        wait_state(S_IDLE, 300, "t3_idle");

        // Rejected starts.
        bus.door_closed = 1'b0;
        start_run(5, 4);
        chk("t4_door_state", bus.state, S_IDLE);
        chk("t4_door_mag", bus.magnetron_on, 0);
        chk("t4_door_lamp", bus.lamp_on, 1);
        bus.door_closed = 1'b1;
        start_run(0, 4);
        chk("t4_zero_state", bus.state, S_IDLE);
        chk("t4_zero_time", bus.time_left, 0);

        // Stop and start together -> pause; clear -> idle.
        start_run(8, 4);
        chk("t5_cook", bus.state, S_COOK);
        repeat (3) @(posedge clk);
        press(1'b1, 1'b1, 1'b0);
        chk("t5_pause", bus.state, S_PAUSE);
        chk("t5_time", bus.time_left, 7);
        repeat (8) @(posedge clk);
        #1 chk("t5_time_held", bus.time_left, 7);
        press(1'b0, 1'b0, 1'b1);
        chk("t5_clear_state", bus.state, S_IDLE);
        chk("t5_clear_time", bus.time_left, 0);

        // Held start acts once.
        push_exp(1'b1, 8, 8, 8);
        bus.time_load   = 8'd2;
        bus.power_level = 3'd4;
        @(posedge clk); #1 bus.startn = 1'b0;
        repeat (50) @(posedge clk);
        #1 chk("t6_held_idle", bus.state, S_IDLE);
        bus.startn = 1'b1;

        // Reset mid-cook.
        start_run(8, 4);
        repeat (6) @(posedge clk);
        #1 chk("t6_mag_on", bus.magnetron_on, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t6_rst_state", bus.state, S_IDLE);
        chk("t6_rst_time", bus.time_left, 0);
        chk("t6_rst_mag", bus.magnetron_on, 0);
        chk("t6_rst_beep", bus.beep, 0);
        chk("t6_rst_done", bus.done_pulse, 0);
        rst = 1'b0;

        // Power 0 and power above range both mean full power.
        push_exp(1'b1, 8, 8, 8);
        start_run(2, 0);
        wait_state(S_IDLE, 300, "p0_idle");
        push_exp(1'b1, 4, 4, 8);
        start_run(1, 7);
        wait_state(S_IDLE, 300, "p7_idle");

        // Clear during DONE cuts the beep short.
        push_exp(1'b1, 4, 4, 3);
        start_run(1, 4);
        wait_state(S_DONE, 300, "dn_reach");
        press(1'b0, 1'b0, 1'b1);
        chk("dn_clear_idle", bus.state, S_IDLE);
        @(negedge clk);

        chk("sb_drained", sb.size(), 0);
        chk("done_count", done_seen, pushed);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
